// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the PWM compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int PWM_DEFAULT_MOD_VALUE = 32;

    // Counter width for a given modulus; duty values need one extra bit so
    // that a full-period duty (P) is representable.
    function automatic int pwm_cnt_width(input int mod_value);
        return (mod_value <= 2) ? 1 : $clog2(mod_value);
    endfunction

    localparam int PWM_DEFAULT_W = pwm_cnt_width(PWM_DEFAULT_MOD_VALUE);

    typedef logic [PWM_DEFAULT_W:0] duty_t;

    localparam int PWM_DUTY_RESET   = 0;
    localparam int PWM_MAX_DEADTIME = 15;

    // Run-length counter must be able to hold PWM_MAX_DEADTIME + 1.
    localparam int PWM_RUN_W = $clog2(PWM_MAX_DEADTIME + 2);

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_compare_unit_if.sv
// ============================================================================
// Module      : pwm_compare_unit_if
// Description : Valid/ready duty-update channel into the PWM compare unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_compare_unit_if #(
    parameter int MOD_VALUE = 32
);

    localparam int W = $clog2(MOD_VALUE);

    logic [W:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface : pwm_compare_unit_if

`default_nettype wire

// File: rtl/pwm_compare_unit_deadtime.sv
// ============================================================================
// Module      : pwm_deadtime
// Description : Dead-time insertion stage producing non-overlapping
//               complementary outputs from a raw compare result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEADTIME = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw,
    output logic      pwm_out,
    output logic      pwm_n_out
);

    localparam logic [PWM_RUN_W-1:0] c_RUN_MAX = PWM_RUN_W'(PWM_MAX_DEADTIME + 1);
    localparam logic [PWM_RUN_W-1:0] c_DEAD    = PWM_RUN_W'(DEADTIME);
    localparam logic [PWM_RUN_W-1:0] c_RUN_ONE = PWM_RUN_W'(1);

    logic                 r_raw_d;
    logic [PWM_RUN_W-1:0] r_run;
    logic                 r_pwm;
    logic                 r_pwm_n;
    logic                 w_level_change;

    assign w_level_change = raw ^ r_raw_d;

    // r_run counts consecutive samples equal to r_raw_d, including r_raw_d
    // itself; reset counts as a break so both sides restart their dead-time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_raw_d <= 1'b0;
            r_run   <= '0;
            r_pwm   <= 1'b0;
            r_pwm_n <= 1'b0;
        end else begin
            r_raw_d <= raw;
            if (w_level_change) begin
                r_run <= c_RUN_ONE;
            end else if (r_run != c_RUN_MAX) begin
                r_run <= r_run + c_RUN_ONE;
            end
            r_pwm   <=  r_raw_d & (r_run > c_DEAD);
            r_pwm_n <= ~r_raw_d & (r_run > c_DEAD);
        end
    end

    assign pwm_out   = r_pwm;
    assign pwm_n_out = r_pwm_n;

endmodule : pwm_deadtime

`default_nettype wire

// File: rtl/pwm_compare_unit.sv
// ============================================================================
// Module      : pwm_compare_unit
// Description : Registered PWM compare against an external down-count with a
//               shadowed duty register applied at the period boundary.
//               Optional dead-time stage enabled by PWM_DEADTIME_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_compare_unit
    import pwm_pkg::*;
#(
    parameter int MOD_VALUE = 32
`ifdef PWM_DEADTIME_EN
   ,parameter int DEADTIME  = 2
`endif
   ,localparam int W        = $clog2(MOD_VALUE)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic [W-1:0]   cnt_in,
    pwm_compare_unit_if.slave   duty_if,
    output logic                pwm_out,
`ifdef PWM_DEADTIME_EN
    output logic                pwm_n_out,
`endif
    output logic                period_start
);

    localparam logic [W:0] c_PERIOD     = {1'b1, {W{1'b0}}};
    localparam logic [W:0] c_DUTY_RESET = (W+1)'(PWM_DUTY_RESET);

    logic [W:0] r_duty_active;
    logic [W:0] r_shadow;
    logic       r_shadow_full;

    logic       w_boundary;
    logic       w_ready;
    logic       w_accept;
    logic       w_apply;
    logic       w_raw;
    logic [W:0] w_duty_clamped;
    logic [W:0] w_duty_eff;

    assign w_boundary     = &cnt_in;
    assign w_ready        = rst & ~r_shadow_full;
    assign w_accept       = duty_if.duty_valid & w_ready;
    assign w_apply        = w_boundary & r_shadow_full;
    assign w_duty_clamped = (duty_if.duty_in > c_PERIOD) ? c_PERIOD : duty_if.duty_in;

    // The boundary sample itself already uses the incoming duty, so a full
    // duty never shows a low glitch at the wrap.
    assign w_duty_eff     = w_apply ? r_shadow : r_duty_active;
    assign w_raw          = ({1'b0, cnt_in} < w_duty_eff);

    assign duty_if.duty_ready = w_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_duty_active <= c_DUTY_RESET;
            r_shadow      <= c_DUTY_RESET;
            r_shadow_full <= 1'b0;
        end else if (w_apply) begin
            r_duty_active <= r_shadow;
            r_shadow_full <= 1'b0;
        end else if (w_accept) begin
            r_shadow      <= w_duty_clamped;
            r_shadow_full <= 1'b1;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic r_period_d1;
    logic r_period_start;

    // period_start carries one extra stage to stay aligned with the
    // dead-time pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_period_d1    <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_period_d1    <= w_boundary;
            r_period_start <= r_period_d1;
        end
    end

    assign period_start = r_period_start;

    pwm_deadtime #(
        .DEADTIME  (DEADTIME)
    ) u_deadtime (
        .clk       (clk),
        .rst       (rst),
        .raw       (w_raw),
        .pwm_out   (pwm_out),
        .pwm_n_out (pwm_n_out)
    );
`else
    logic r_pwm;
    logic r_period_start;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= w_raw;
            r_period_start <= w_boundary;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
`endif

endmodule : pwm_compare_unit

`default_nettype wire

// File: tb/tb_pwm_compare_unit.sv
// ============================================================================
// Module      : tb_pwm_compare_unit
// Description : Randomised scoreboard bench for pwm_compare_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_compare_unit;
    import pwm_pkg::*;

    localparam int MOD_VALUE = 32;
    localparam int W         = $clog2(MOD_VALUE);
    localparam int P         = 2 ** W;
`ifdef PWM_DEADTIME_EN
    localparam int DEADTIME  = 2;
`endif

    logic         clk = 1'b1;
    logic         rst = 1'b0;
    logic [W-1:0] cnt_in = '0;
    logic         pwm_out;
    logic         period_start;
`ifdef PWM_DEADTIME_EN
    logic         pwm_n_out;
`endif

    pwm_compare_unit_if #(.MOD_VALUE(MOD_VALUE)) duty_if ();

    pwm_compare_unit #(
        .MOD_VALUE    (MOD_VALUE)
`ifdef PWM_DEADTIME_EN
       ,.DEADTIME     (DEADTIME)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt_in       (cnt_in),
        .duty_if      (duty_if.slave),
        .pwm_out      (pwm_out),
`ifdef PWM_DEADTIME_EN
        .pwm_n_out    (pwm_n_out),
`endif
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pwm;
        bit pwm_n;
        bit ps;
        bit ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: duty in force for the current period and the duty
    // waiting for the next boundary (-1 = none waiting).
    int   active  = 0;
    int   pending = -1;
    int   phase   = 20;
    bit   last_accepted = 0;
    int   hist_raw[$];   // 0/1 sample, 2 = reset cycle (breaks any run)
    int   hist_bnd[$];

    task automatic check(input string name, input bit act, input bit expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, expv);
        end
    endtask

    // One clock of stimulus; predicts what the DUT shows after the next edge.
    task automatic step(input bit r, input bit v, input int d);
        exp_t e;
        bit   bnd;
        bit   rdy;
        int   rawv;
        int   eff;
        @(negedge clk);
        rst                = r;
        cnt_in             = W'(phase);
        duty_if.duty_valid = v;
        duty_if.duty_in    = (W+1)'(d);
        bnd                = (phase == P - 1);
        rdy                = r && (pending < 0);
        last_accepted      = 0;
        if (!r) begin
            active  = 0;
            pending = -1;
            rawv    = 2;
        end else begin
            eff  = (bnd && pending >= 0) ? pending : active;
            rawv = (phase < eff) ? 1 : 0;
            if (bnd && pending >= 0) begin
                active  = pending;
                pending = -1;
            end else if (v && rdy) begin
                pending       = (d > P) ? P : d;
                last_accepted = 1;
            end
        end
`ifdef PWM_DEADTIME_EN
        begin
            int n;
            int lvl;
            bit ok;
            n   = hist_raw.size();
            lvl = (n > 0) ? hist_raw[n-1] : 2;
            ok  = (lvl != 2);
            for (int k = 1; k <= DEADTIME; k++) begin
                if (n - 1 - k < 0 || hist_raw[n-1-k] != lvl) ok = 0;
            end
            e.pwm   = r && ok && (lvl == 1);
            e.pwm_n = r && ok && (lvl == 0);
            e.ps    = r && (hist_bnd.size() > 0) && (hist_bnd[hist_bnd.size()-1] == 1);
        end
`else
        e.pwm   = (rawv == 1);
        e.pwm_n = 0;
        e.ps    = r && bnd;
`endif
        hist_raw.push_back(rawv);
        hist_bnd.push_back((r && bnd) ? 1 : 0);
        if (hist_raw.size() > 64) begin
            void'(hist_raw.pop_front());
            void'(hist_bnd.pop_front());
        end
        e.ready = r && (pending < 0);
        exp_q.push_back(e);
        phase = (phase == 0) ? P - 1 : phase - 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, int'($urandom_range(0, 63)));
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < P && phase != target; i++) step(1, 0, 0);
    endtask

    // Holds valid until the handshake completes, bounded to a few periods.
    task automatic send(input int d);
        bit done;
        done = 0;
        for (int i = 0; i < 3 * P && !done; i++) begin
            step(1, 1, d);
            done = last_accepted;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout duty %0d: accepted 0 expected 1", d);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                check("pwm_out", pwm_out, e.pwm);
                check("period_start", period_start, e.ps);
                check("duty_ready", duty_if.duty_ready, e.ready);
`ifdef PWM_DEADTIME_EN
                check("pwm_n_out", pwm_n_out, e.pwm_n);
                check("overlap", pwm_out & pwm_n_out, 1'b0);
`endif
            end
        end
    end

    initial begin : stimulus
        duty_if.duty_valid = 1'b0;
        duty_if.duty_in    = '0;
        for (int i = 0; i < 3; i++) step(0, 1, 8);
        idle(2);
        wait_phase(15);
        send(8);
        idle(2 * P);
        send(40);
        idle(2 * P);
        send(4);
        send(20);
        idle(2 * P);
        wait_phase(P - 1);
        send(12);
        idle(2 * P);
        send(1);
        idle(2 * P);
        send(0);
        idle(P);
        wait_phase(10);
        step(0, 0, 0);
        step(0, 1, 30);
        idle(P);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 63)));
        end
        idle(4);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pwm_compare_unit

`default_nettype wire
